// File: rtl/dmem_pkg.sv
// Shared constants for the data memory controller: access-size encodings,
// FSM states and byte-lane enable decoding.
package dmem_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Lane is expected already aligned for halfword and word accesses.
   function automatic logic [LANES-1:0] lane_enables(input logic [2:0] ctrl,
                                                    input logic [1:0] lane);
      logic [LANES-1:0] be;
      case (ctrl)
         CTRL_B, CTRL_BU: be = LANES'(1) << lane;
         CTRL_H, CTRL_HU: be = lane[1] ? 4'b1100 : 4'b0011;
         CTRL_W:          be = '1;
         default:         be = '0;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage split into independent byte lanes: synchronous
// byte-enabled write, combinational read. Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [LANES-1:0]               be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];

         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               mem[idx] <= wdata[gi*8 +: 8];
            end
         end

         assign rdata[gi*8 +: 8] = mem[idx];
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: request handshake, fixed-latency response FSM,
// lane select and load extension. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Req,
   output logic        ReqReady,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic        RspValid,
   output logic [31:0] DataRd,
   output logic        AccessErr
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [1:0] CNT_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [31:0] word_reg;
   logic [2:0]  ctrl_reg;
   logic [1:0]  lane_reg;
   logic        err_reg;
   logic        store_reg;

   logic             accept;
   logic             ctrl_ok;
   logic             is_half;
   logic             is_word;
   logic             range_err;
   logic             req_err;
   logic [1:0]       lane;
   logic [LANES-1:0] be;
   logic             we;
   logic [31:0]      wdata;
   logic [31:0]      rd_word;
   logic [31:0]      shifted;
   logic [31:0]      load_data;

   assign accept    = Req & ReqReady;
   assign is_half   = (DMCtrl == CTRL_H) || (DMCtrl == CTRL_HU);
   assign is_word   = (DMCtrl == CTRL_W);
   assign range_err = (Address[31:IDX_W+2] != '0);

   // Unsigned sizes only make sense for loads.
   always_comb begin
      case (DMCtrl)
         CTRL_B, CTRL_H, CTRL_W: ctrl_ok = 1'b1;
         CTRL_BU, CTRL_HU:       ctrl_ok = !DMWr;
         default:                ctrl_ok = 1'b0;
      endcase
   end

   always_comb begin
      if (is_word) begin
         lane = 2'b00;
      end else if (is_half) begin
         lane = {Address[1], 1'b0};
      end else begin
         lane = Address[1:0];
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (is_half && Address[0]) || (is_word && (Address[1:0] != 2'b00));
   assign req_err    = !ctrl_ok || range_err || misaligned;
`else
   assign req_err    = !ctrl_ok || range_err;
`endif

   assign be = lane_enables(DMCtrl, lane);
   // Gating with rst keeps a store that coincides with reset out of the array.
   assign we = accept && DMWr && !req_err && !rst;

   always_comb begin
      case (DMCtrl)
         CTRL_B:  wdata = {4{DataWr[7:0]}};
         CTRL_H:  wdata = {2{DataWr[15:0]}};
         default: wdata = DataWr;
      endcase
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .idx   (Address[IDX_W+1:2]),
      .wdata (wdata),
      .rdata (rd_word)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (Req) begin
               cnt_next   = 2'd0;
               state_next = (LATENCY > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end
         RESP: begin
            state_next = IDLE;
            cnt_next   = 2'd0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 2'd0;
         word_reg  <= '0;
         ctrl_reg  <= CTRL_B;
         lane_reg  <= 2'b00;
         err_reg   <= 1'b0;
         store_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            word_reg  <= rd_word;
            ctrl_reg  <= DMCtrl;
            lane_reg  <= lane;
            err_reg   <= req_err;
            store_reg <= DMWr;
         end
      end
   end

   assign shifted = word_reg >> {lane_reg, 3'b000};

   always_comb begin
      case (ctrl_reg)
         CTRL_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         CTRL_BU: load_data = {24'b0, shifted[7:0]};
         CTRL_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         CTRL_HU: load_data = {16'b0, shifted[15:0]};
         CTRL_W:  load_data = shifted;
         default: load_data = '0;
      endcase
   end

   assign ReqReady  = (state_reg == IDLE);
   assign RspValid  = (state_reg == RESP);
   assign DataRd    = (RspValid && !store_reg && !err_reg) ? load_data : 32'h0;
   assign AccessErr = RspValid && err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one LATENCY=1 and one LATENCY=3 instance
// sharing request fields, each with its own Req.
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req1, req3;
   logic [31:0] address, data_wr;
   logic        dm_wr;
   logic [2:0]  dm_ctrl;
   logic        rdy1, rsp1, err1, rdy3, rsp3, err3;
   logic [31:0] rd1, rd3;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .Req(req1), .ReqReady(rdy1), .Address(address),
      .DataWr(data_wr), .DMWr(dm_wr), .DMCtrl(dm_ctrl), .RspValid(rsp1),
      .DataRd(rd1), .AccessErr(err1)
   );

   data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .Req(req3), .ReqReady(rdy3), .Address(address),
      .DataWr(data_wr), .DMWr(dm_wr), .DMCtrl(dm_ctrl), .RspValid(rsp3),
      .DataRd(rd3), .AccessErr(err3)
   );

   function automatic logic f_rdy(input int sel);
      return (sel == 3) ? rdy3 : rdy1;
   endfunction
   function automatic logic f_rsp(input int sel);
      return (sel == 3) ? rsp3 : rsp1;
   endfunction
   function automatic logic f_err(input int sel);
      return (sel == 3) ? err3 : err1;
   endfunction
   function automatic logic [31:0] f_rd(input int sel);
      return (sel == 3) ? rd3 : rd1;
   endfunction

   // Single access: issue, push expectation on acceptance, pop on RspValid.
   task automatic access(input int sel, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input string name);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clk);
      while (!f_rdy(sel) && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!f_rdy(sel)) begin
         fails++;
         $display("FAIL %s ready_timeout: ReqReady=0 required 1", name);
         return;
      end
      address = addr; data_wr = wdata; dm_wr = wr; dm_ctrl = ctrl;
      if (sel == 3) req3 = 1'b1; else req1 = 1'b1;
      @(posedge clk);
      e.data = exp_data; e.err = exp_err; e.lat = (sel == 3) ? 3 : 1;
      sb.push_back(e);
      @(negedge clk);
      req1 = 1'b0; req3 = 1'b0;
      address = $urandom; data_wr = $urandom; dm_wr = 1'($urandom); dm_ctrl = 3'($urandom);
      checks++;
      if (f_rdy(sel) !== 1'b0) begin
         fails++;
         $display("FAIL %s busy_ready: ReqReady=%b required 0", name, f_rdy(sel));
      end
      t = 1;
      while (!f_rsp(sel) && t < 10) begin
         @(negedge clk);
         t++;
      end
      e = sb.pop_front();
      checks++;
      if (!f_rsp(sel)) begin
         fails++;
         $display("FAIL %s rsp_timeout: RspValid=0 required 1", name);
         return;
      end
      checks++;
      if (t !== e.lat) begin
         fails++;
         $display("FAIL %s latency: got %0d required %0d", name, t, e.lat);
      end
      checks++;
      if (f_rd(sel) !== e.data) begin
         fails++;
         $display("FAIL %s data: got %h required %h", name, f_rd(sel), e.data);
      end
      checks++;
      if (f_err(sel) !== e.err) begin
         fails++;
         $display("FAIL %s err: got %b required %b", name, f_err(sel), e.err);
      end
      $display("TXN dut%0d %-14s addr=%h data=%h err=%b lat=%0d", sel, name, addr, f_rd(sel), f_err(sel), t);
      @(negedge clk);
      checks++;
      if (f_rsp(sel) !== 1'b0 || f_rd(sel) !== 32'h0 || f_err(sel) !== 1'b0) begin
         fails++;
         $display("FAIL %s pulse: rsp=%b data=%h err=%b required 0/0/0", name, f_rsp(sel), f_rd(sel), f_err(sel));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req1 = 1'b0; req3 = 1'b0;
      address = '0; data_wr = '0; dm_wr = 1'b0; dm_ctrl = CTRL_W;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({rdy1, rsp1, err1, rdy3, rsp3, err3} !== 6'b100100 || rd1 !== 32'h0 || rd3 !== 32'h0) begin
         fails++;
         $display("FAIL reset_state: rdy/rsp/err=%b%b%b %b%b%b rd=%h %h required 100 100 0 0",
                  rdy1, rsp1, err1, rdy3, rsp3, err3, rd1, rd3);
      end
      $display("TXN reset state checked");
   endtask

   task automatic test_word();
      access(1, 1'b1, CTRL_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "SW 0x10");
      access(1, 1'b0, CTRL_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "LW 0x10");
      access(1, 1'b1, CTRL_W, 32'h3FC, 32'h0BADF00D, 32'h0, 1'b0, "SW 0x3FC");
      access(1, 1'b0, CTRL_W, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, "LW 0x3FC");
   endtask

   task automatic test_subword();
      access(1, 1'b1, CTRL_B,  32'h13, 32'h00000080, 32'h0, 1'b0, "SB 0x13");
      access(1, 1'b0, CTRL_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "LB 0x13");
      access(1, 1'b0, CTRL_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, "LBU 0x13");
      access(1, 1'b0, CTRL_H,  32'h12, 32'h0, 32'hFFFF80AD, 1'b0, "LH 0x12");
      access(1, 1'b0, CTRL_HU, 32'h12, 32'h0, 32'h000080AD, 1'b0, "LHU 0x12");
      access(1, 1'b0, CTRL_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "LB 0x10");
      access(1, 1'b0, CTRL_BU, 32'h11, 32'h0, 32'h000000BE, 1'b0, "LBU 0x11");
      access(1, 1'b0, CTRL_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "LH 0x10");
      access(1, 1'b1, CTRL_W,  32'h14, 32'h0, 32'h0, 1'b0, "SW 0x14");
      access(1, 1'b1, CTRL_H,  32'h16, 32'h0000CAFE, 32'h0, 1'b0, "SH 0x16");
      access(1, 1'b0, CTRL_W,  32'h14, 32'h0, 32'hCAFE0000, 1'b0, "LW 0x14");
   endtask

   task automatic test_errors();
      access(1, 1'b1, CTRL_W, 32'h0, 32'h55AA55AA, 32'h0, 1'b0, "SW 0x000");
      access(1, 1'b1, CTRL_W, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, "SW 0x400");
      access(1, 1'b0, CTRL_W, 32'h0, 32'h0, 32'h55AA55AA, 1'b0, "LW 0x000");
      access(1, 1'b0, CTRL_W, 32'h400, 32'h0, 32'h0, 1'b1, "LW 0x400");
      access(1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "LD ctrl=011");
      access(1, 1'b1, 3'b111, 32'h10, 32'h12345678, 32'h0, 1'b1, "ST ctrl=111");
      access(1, 1'b0, CTRL_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "LW 0x10 keep");
   endtask

   task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
      access(1, 1'b0, CTRL_W, 32'h11, 32'h0, 32'h0, 1'b1, "LW 0x11");
      access(1, 1'b0, CTRL_H, 32'h13, 32'h0, 32'h0, 1'b1, "LH 0x13");
      access(1, 1'b1, CTRL_H, 32'h17, 32'h00007777, 32'h0, 1'b1, "SH 0x17");
      access(1, 1'b0, CTRL_W, 32'h14, 32'h0, 32'hCAFE0000, 1'b0, "LW 0x14 mis");
`else
      access(1, 1'b0, CTRL_W, 32'h11, 32'h0, 32'h80ADBEEF, 1'b0, "LW 0x11");
      access(1, 1'b0, CTRL_H, 32'h13, 32'h0, 32'hFFFF80AD, 1'b0, "LH 0x13");
      access(1, 1'b1, CTRL_H, 32'h17, 32'h00007777, 32'h0, 1'b0, "SH 0x17");
      access(1, 1'b0, CTRL_W, 32'h14, 32'h0, 32'h77770000, 1'b0, "LW 0x14 mis");
`endif
   endtask

   // Req held high on the LATENCY=3 instance.
   task automatic test_back_to_back();
      int exp_rsp[$];
      int acc_n[$];
      int e;
      access(3, 1'b1, CTRL_W, 32'h20, 32'h12345678, 32'h0, 1'b0, "SW 0x20 L3");
      address = 32'h20; dm_wr = 1'b0; dm_ctrl = CTRL_W; data_wr = '0; req3 = 1'b1;
      for (int n = 0; n < 16; n++) begin
         if (rsp3) begin
            checks++;
            if (exp_rsp.size() == 0) begin
               fails++;
               $display("FAIL b2b unexpected_rsp: cycle %0d with empty scoreboard", n);
            end else begin
               e = exp_rsp.pop_front();
               if (e !== n) begin
                  fails++;
                  $display("FAIL b2b rsp_cycle: got %0d required %0d", n, e);
               end
            end
            checks++;
            if (rd3 !== 32'h12345678) begin
               fails++;
               $display("FAIL b2b data: got %h required 12345678", rd3);
            end
            $display("TXN dut3 b2b LW 0x20 data=%h err=%b cycle=%0d", rd3, err3, n);
         end
         if (rdy3) begin
            exp_rsp.push_back(n + 3);
            acc_n.push_back(n);
         end
         @(negedge clk);
      end
      req3 = 1'b0;
      checks++;
      if (acc_n.size() != 4 || exp_rsp.size() != 0) begin
         fails++;
         $display("FAIL b2b counts: accepts=%0d pending=%0d required 4 and 0", acc_n.size(), exp_rsp.size());
      end
      for (int i = 1; i < acc_n.size(); i++) begin
         checks++;
         if (acc_n[i] - acc_n[i-1] != 4) begin
            fails++;
            $display("FAIL b2b spacing: got %0d required 4", acc_n[i] - acc_n[i-1]);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      int seen;
      @(negedge clk);
      address = 32'h20; dm_wr = 1'b0; dm_ctrl = CTRL_W; req3 = 1'b1;
      @(negedge clk);
      req3 = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (rdy3 !== 1'b1 || rsp3 !== 1'b0) begin
         fails++;
         $display("FAIL rst_wait state: ReqReady=%b RspValid=%b required 1 0", rdy3, rsp3);
      end
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp3) seen++;
      end
      checks++;
      if (seen != 0) begin
         fails++;
         $display("FAIL rst_wait dropped: %0d responses required 0", seen);
      end
      $display("TXN dut3 reset in WAIT, responses after reset=%0d", seen);
      access(3, 1'b0, CTRL_W, 32'h20, 32'h0, 32'h12345678, 1'b0, "LW 0x20 L3");
   endtask

   task automatic test_store_at_reset();
      access(1, 1'b1, CTRL_W, 32'h30, 32'h11111111, 32'h0, 1'b0, "SW 0x30");
      @(negedge clk);
      address = 32'h30; data_wr = 32'hAAAAAAAA; dm_wr = 1'b1; dm_ctrl = CTRL_W;
      req1 = 1'b1; rst = 1'b1;
      @(negedge clk);
      req1 = 1'b0; rst = 1'b0;
      checks++;
      if (rsp1 !== 1'b0 || rdy1 !== 1'b1) begin
         fails++;
         $display("FAIL rst_store state: RspValid=%b ReqReady=%b required 0 1", rsp1, rdy1);
      end
      access(1, 1'b0, CTRL_W, 32'h30, 32'h0, 32'h11111111, 1'b0, "LW 0x30");
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_errors();
      test_misalign();
      test_back_to_back();
      test_reset_in_wait();
      test_store_at_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
